// File: rtl/sp_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// sp_ram_stream_reader
//
// Reads a block of len_i consecutive 32-bit words from a single-port RAM,
// starting at byte address base_addr_i (word aligned by clearing bits [1:0]).
// The words are emitted in address order on a valid/ready stream. A small
// output FIFO absorbs the one-cycle RAM read latency so that consumer
// backpressure never drops or duplicates a word.
//
// Ports
//   clk, rstn_i                  clock, asynchronous active-low reset
//   start_i                      one-cycle request, only looked at in IDLE
//   base_addr_i, len_i           byte start address, number of words
//   busy_o                       high while reading or draining
//   done_o                       one-cycle pulse once the last word is taken
//   ram_en_o, ram_addr_o         RAM read strobe and byte address
//   ram_we_o, ram_be_o,
//   ram_wdata_o                  write side, tied off (read-only initiator)
//   ram_rdata_i                  RAM read data, valid the cycle after ram_en_o
//   data_o, valid_o, ready_i     output stream (data_o is the FIFO head)
// -----------------------------------------------------------------------------
module sp_ram_stream_reader #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 13,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rstn_i,
   input  logic                    start_i,
   input  logic [ADDR_WIDTH-1:0]   base_addr_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    valid_o,
   input  logic                    ready_i
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);

   // Control state
   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  remain_q;

   // A read issued in the previous cycle whose data is on ram_rdata_i now
   logic                  vld_p1;

   // Output FIFO
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  last_issue;
   logic                  drain_empty;
   logic [OCC_W-1:0]      occ_after;

   // Circular pointer advance; works for depths that are not a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Issue decision
   // ---------------------------------------------------------------------------
   assign push = vld_p1;
   assign pop  = valid_o & ready_i;

   // Entries that will be committed to the FIFO once the pending capture lands
   // and this cycle's pop leaves. A new read is only issued if its data is
   // guaranteed a free slot, so the FIFO can never overflow.
   assign occ_after  = OCC_W'(count_q) + OCC_W'(vld_p1) - OCC_W'(pop);
   assign issue      = (state_q == S_READ) && (occ_after < OCC_W'(FIFO_DEPTH));
   assign last_issue = issue && (remain_q == LEN_WIDTH'(1));

   // Everything has been handed to the consumer once this cycle's pop empties
   // the FIFO and no capture is still pending.
   assign drain_empty = !vld_p1 && (count_q == CNT_W'(pop));

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = (len_i != '0) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            if (last_issue) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_empty) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Stage p0: FSM, address generation and read issue
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         vld_p1   <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_p1  <= issue;
         if ((state_q == S_IDLE) && start_i && (len_i != '0)) begin
            addr_q   <= base_addr_i & ALIGN_MASK;
            remain_q <= len_i;
         end else if (issue) begin
            // Natural wrap modulo 2^ADDR_WIDTH
            addr_q   <= addr_q + WORD_STEP;
            remain_q <= remain_q - LEN_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p1: capture RAM data into the FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= ram_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign valid_o = (count_q != '0);

   // The FIFO storage itself is not reset; gating with valid_o keeps data_o at
   // zero whenever nothing is being presented, including straight after reset.
   assign data_o  = valid_o ? fifo_mem[rd_ptr_q] : '0;

   assign busy_o  = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done_o  = (state_q == S_DONE);

   assign ram_en_o    = issue;
   assign ram_addr_o  = addr_q;
   assign ram_we_o    = 1'b0;
   assign ram_be_o    = '1;
   assign ram_wdata_o = '0;

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
module tb_sp_ram_stream_reader;

   localparam int AW    = 15;
   localparam int DW    = 32;
   localparam int LW    = 13;
   localparam int DEPTH = 2;

   logic          clk;
   logic          rstn_i;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [LW-1:0] len_i;
   logic          busy_o;
   logic          done_o;
   logic          ram_en_o;
   logic [AW-1:0] ram_addr_o;
   logic          ram_we_o;
   logic [3:0]    ram_be_o;
   logic [DW-1:0] ram_wdata_o;
   logic [DW-1:0] ram_rdata_i;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural RAM: 8192 words, one-cycle registered read
   logic [31:0] mem [0:8191];

   sp_ram_stream_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rstn_i      (rstn_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en_o) ram_rdata_i <= mem[ram_addr_o[14:2]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick_ready(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 2 && k >= 6 && k <= 10) return 1'b0;
      return 1'($urandom % 2);
   endfunction

   // Start one transfer from the current (pre-edge) cycle and follow it to done.
   // Reference: the transfer reads words at ((base & ~3) + 4*i) mod 2^15 and
   // must deliver exactly those words, in order, each accepted once.
   task automatic run_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input int rmode, input string tag);
      logic [31:0]   exp_q[$];
      logic [AW-1:0] addr_q[$];
      logic [AW-1:0] a;
      logic [31:0]   prev_data;
      logic          prev_hold;
      logic          done_busy;
      bit            we_bad, busy_bad;
      int            issued, accepted, max_out, first_en, first_vld, done_cyc;

      for (int i = 0; i < int'(len); i++) begin
         a = (base & 15'h7FFC) + 15'(4 * i);
         addr_q.push_back(a);
         exp_q.push_back(mem[a[14:2]]);
      end
      issued = 0; accepted = 0; max_out = 0;
      first_en = -1; first_vld = -1; done_cyc = -1;
      prev_hold = 1'b0; prev_data = '0; done_busy = 1'b0;
      we_bad = 0; busy_bad = 0;

      start_i = 1'b1; base_addr_i = base; len_i = len;
      ready_i = pick_ready(rmode, 0);

      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         ready_i = pick_ready(rmode, k);
         @(negedge clk);
         if (ram_we_o !== 1'b0) we_bad = 1;
         if (ram_en_o) begin
            if (first_en < 0) first_en = k;
            issued++;
            if (addr_q.size() == 0) chk({tag, "_extra_issue"}, 64'(ram_addr_o), 64'h7FFFFFFF);
            else chk({tag, "_addr"}, 64'(ram_addr_o), 64'(addr_q.pop_front()));
         end
         if (valid_o && first_vld < 0) first_vld = k;
         if (prev_hold) chk({tag, "_hold"}, {31'd0, valid_o, data_o}, {31'd0, 1'b1, prev_data});
         if (valid_o && ready_i) begin
            accepted++;
            if (exp_q.size() == 0) chk({tag, "_extra_word"}, 64'(data_o), 64'hFFFFFFFFF);
            else chk({tag, "_data"}, 64'(data_o), 64'(exp_q.pop_front()));
         end
         prev_hold = valid_o && !ready_i;
         prev_data = data_o;
         if (issued - accepted > max_out) max_out = issued - accepted;
         if (done_o) begin
            done_cyc  = k;
            done_busy = busy_o;
            break;
         end
         if (busy_o !== (len != '0)) busy_bad = 1;
      end

      chk({tag, "_finished"}, 64'(done_cyc > 0), 64'd1);
      chk({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
      chk({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_issue_count"}, 64'(issued), 64'(len));
      chk({tag, "_we_zero"}, 64'(we_bad), 64'd0);
      chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
      chk({tag, "_occupancy"}, 64'(max_out <= DEPTH), 64'd1);
      if (rmode == 0) begin
         chk({tag, "_first_en_cyc"}, 64'(first_en), (len != '0) ? 64'd1 : 64'(-1));
         chk({tag, "_first_vld_cyc"}, 64'(first_vld), (len != '0) ? 64'd3 : 64'(-1));
         chk({tag, "_done_cyc"}, 64'(done_cyc), (len != '0) ? 64'(int'(len) + 3) : 64'd1);
      end

      // done_o is a single pulse and the block returns to idle
      @(posedge clk); #1;
      ready_i = 1'b1;
      @(negedge clk);
      chk({tag, "_after_done"}, {60'd0, done_o, busy_o, valid_o, ram_en_o}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = $urandom;
      for (int i = 0; i < 8; i++) mem[(16'h0100 >> 2) + i] = 32'h1000_0000 + 32'(i);

      rstn_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
      base_addr_i = '0; len_i = '0;

      @(negedge clk);
      chk("reset_outputs", {busy_o, done_o, ram_en_o, valid_o, 15'(ram_addr_o), data_o}, 64'd0);
      chk("tieoff_be", 64'(ram_be_o), 64'hF);
      chk("tieoff_wdata", 64'(ram_wdata_o), 64'd0);
      chk("tieoff_we", 64'(ram_we_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rstn_i = 1'b1;
      @(negedge clk);

      run_xfer(15'h0100, 13'd4, 0, "basic");
      run_xfer(15'h0000, 13'd0, 0, "len0");
      run_xfer(15'h7FFC, 13'd3, 0, "wrap");
      run_xfer(15'h0203, 13'd1, 0, "misalign");
      run_xfer(15'h0100, 13'd8, 2, "backpressure");

      // Reset in cycle 4 of a len=8 transfer
      @(negedge clk);
      start_i = 1'b1; base_addr_i = 15'h0100; len_i = 13'd8; ready_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn_i = 1'b0;
      #1;
      chk("midrst_outputs", {busy_o, done_o, ram_en_o, valid_o, 15'(ram_addr_o), data_o}, 64'd0);
      @(posedge clk); #1 rstn_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_quiet", {61'd0, valid_o, busy_o, ram_en_o}, 64'd0);
      end
      run_xfer(15'h0000, 13'd2, 0, "post_reset");

      for (int t = 0; t < 6; t++) begin
         run_xfer(15'($urandom), 13'($urandom_range(1, 24)), 1, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
